decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter LOAD_LAT, default 2, giving the load-use stall length in cycles (legal 1..7).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the issued-instruction counter.
REQ-003 Clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream fetch presents an instruction.
REQ-006 inst  input  9  instruction word.
REQ-007 in_ready  output  1  block accepts inst this cycle.
REQ-008 out_ready  input  1  downstream ALU/memory stage accepts the decoded bundle.
REQ-009 out_valid  output  1  decoded bundle valid.
REQ-010 alu_op  output  3  ADD=000 LSL=001 XOR=010 AND=011 CMP=100 SET=101 LSR=110 SUB=111.
REQ-011 is_data  output  1  1 = data-class instruction, 0 = arithmetic.
REQ-012 data_op  output  2  MOVE=00 FLAG=01 STORE=10 LOAD=11.
REQ-013 rs_addr, rd_addr  output  3 each  source and destination register numbers.
REQ-014 imm  output  5  immediate field.
REQ-015 reg_we, mem_we, mem_re, flag_we  output  1 each  write/read strobes qualified by out_valid.
REQ-016 issued_cnt  output  CNT_W  count of bundles handed downstream.

Function
REQ-017 Decode SHALL use inst[8] as class: 0 arithmetic, 1 data.
REQ-018 Arithmetic decode SHALL set alu_op=inst[7:5], rs_addr=inst[4:2], rd_addr=0, imm=inst[4:0], data_op=00.
REQ-019 Data decode SHALL set data_op=inst[7:6], rs_addr=inst[5:3], rd_addr=inst[2:0], alu_op=ADD, imm=0.
REQ-020 Strobes SHALL be as follows: reg_we=1 for all arithmetic except CMP, and for MOVE and LOAD; flag_we=1 only for CMP and FLAG; mem_we=1 only for STORE; mem_re=1 only for LOAD.
REQ-021 The output SHALL be a single pipeline register: a bundle captured on an accept edge appears with out_valid=1 on the next cycle (latency 1).
REQ-022 In state RUN, in_ready SHALL be (!out_valid || out_ready) and SHALL depend combinationally on out_ready only.
REQ-023 An accept (in_valid && in_ready) SHALL load the register.
REQ-024 An output handshake with no accept in the same cycle SHALL clear out_valid.
REQ-025 A simultaneous accept and output handshake SHALL replace the bundle with no bubble.
REQ-026 While out_valid=1 and out_ready=0, every output SHALL hold stable.
REQ-027 The FSM SHALL have states RUN and LOAD_STALL.
REQ-028 An output handshake of a LOAD bundle SHALL move the FSM RUN->LOAD_STALL and load stall_cnt=LOAD_LAT.
REQ-029 In LOAD_STALL, in_ready SHALL be 0 and stall_cnt SHALL decrement each cycle; in_ready SHALL assert again in the cycle in which stall_cnt=0 and the FSM returns to RUN.
REQ-030 Back-to-back LOADs SHALL each incur the full stall.
REQ-031 issued_cnt SHALL increment by 1 on each output handshake and wrap from all-ones to 0.

Reset
REQ-032 Assertion of Reset SHALL immediately force out_valid=0, all strobes=0, alu_op/data_op/rs_addr/rd_addr/imm=0, issued_cnt=0, stall_cnt=0, FSM=RUN.
REQ-033 After Reset deasserts, in_ready SHALL be 1.
REQ-034 Reset asserted mid-stall SHALL abandon the stall, and a bundle held under backpressure SHALL be discarded.

Verification
REQ-035 Scenario: inst=0_000_01101 with out_ready=1 -> next cycle out_valid=1, alu_op=000, rs_addr=011, reg_we=1, issued_cnt=1.
REQ-036 Scenario: inst=0_100_00100 (CMP) -> flag_we=1, reg_we=0.
REQ-037 Scenario: inst=1_01_010_011 (FLAG) -> is_data=1, data_op=01, flag_we=1, reg_we=0.
REQ-038 Scenario: LOAD inst=1_11_001_010 handshaken with LOAD_LAT=2 -> in_ready low for exactly 2 cycles, then high; mem_re=1 and rd_addr=010 on the bundle.
REQ-039 Scenario: out_ready=0 for 5 cycles with in_valid=1 -> bundle stable, in_ready=0, and no instruction lost or duplicated after release.
REQ-040 Scenario: preload issued_cnt to FFFF, one handshake -> 0000; Reset asserted during LOAD_STALL -> out_valid=0 and in_ready=1 immediately after release.

Source files
------------

// File: rtl/decode_stage.sv
// Single-register instruction decode stage with valid/ready handshaking,
// a load-use stall after every issued LOAD, and an issued-bundle counter.
module decode_stage #(
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    input  logic [8:0]       i_inst,
    output logic             o_in_ready,
    input  logic             i_out_ready,
    output logic             o_out_valid,
    output logic [2:0]       o_alu_op,
    output logic             o_is_data,
    output logic [1:0]       o_data_op,
    output logic [2:0]       o_rs_addr,
    output logic [2:0]       o_rd_addr,
    output logic [4:0]       o_imm,
    output logic             o_reg_we,
    output logic             o_mem_we,
    output logic             o_mem_re,
    output logic             o_flag_we,
    output logic [CNT_W-1:0] o_issued_cnt
);

    localparam logic [2:0] ALU_CMP    = 3'b100;
    localparam logic [1:0] DOP_MOVE   = 2'b00;
    localparam logic [1:0] DOP_FLAG   = 2'b01;
    localparam logic [1:0] DOP_STORE  = 2'b10;
    localparam logic [1:0] DOP_LOAD   = 2'b11;

    typedef enum logic {RUN, LOAD_STALL} state_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       is_data;
        logic [1:0] data_op;
        logic [2:0] rs_addr;
        logic [2:0] rd_addr;
        logic [4:0] imm;
        logic       reg_we;
        logic       mem_we;
        logic       mem_re;
        logic       flag_we;
    } bundle_t;

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_stall_cnt, w_stall_nxt;
    bundle_t          r_bndl, w_dec;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_issued_cnt;
    logic             w_accept, w_hs, w_hs_load;

    assign w_accept  = i_in_valid && o_in_ready;
    assign w_hs      = r_out_valid && i_out_ready;
    assign w_hs_load = w_hs && r_bndl.is_data && (r_bndl.data_op == DOP_LOAD);

    always_comb begin
        w_dec = '0;
        if (!i_inst[8]) begin
            w_dec.alu_op  = i_inst[7:5];
            w_dec.rs_addr = i_inst[4:2];
            w_dec.imm     = i_inst[4:0];
            w_dec.reg_we  = (i_inst[7:5] != ALU_CMP);
            w_dec.flag_we = (i_inst[7:5] == ALU_CMP);
        end else begin
            w_dec.is_data = 1'b1;
            w_dec.data_op = i_inst[7:6];
            w_dec.rs_addr = i_inst[5:3];
            w_dec.rd_addr = i_inst[2:0];
            case (i_inst[7:6])
                DOP_MOVE:  w_dec.reg_we  = 1'b1;
                DOP_FLAG:  w_dec.flag_we = 1'b1;
                DOP_STORE: w_dec.mem_we  = 1'b1;
                DOP_LOAD: begin
                    w_dec.reg_we = 1'b1;
                    w_dec.mem_re = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= RUN;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_stall_cnt <= w_stall_nxt;
        end
    end

    // A LOAD issuing while already stalled restarts the full stall.
    always_comb begin
        w_state_nxt = r_state;
        w_stall_nxt = r_stall_cnt;
        if (w_hs_load) begin
            w_state_nxt = LOAD_STALL;
            w_stall_nxt = 3'(LOAD_LAT);
        end else if (r_state == LOAD_STALL) begin
            if (r_stall_cnt <= 3'd1) begin
                w_state_nxt = RUN;
                w_stall_nxt = '0;
            end else begin
                w_stall_nxt = r_stall_cnt - 3'd1;
            end
        end
    end

    always_comb begin
        o_in_ready = (r_state == RUN) && (!r_out_valid || i_out_ready);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bndl       <= '0;
            r_out_valid  <= 1'b0;
            r_issued_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_bndl      <= w_dec;
                r_out_valid <= 1'b1;
            end else if (w_hs) begin
                r_out_valid <= 1'b0;
            end
            if (w_hs) begin
                r_issued_cnt <= r_issued_cnt + 1'b1;
            end
        end
    end

    assign o_out_valid  = r_out_valid;
    assign o_alu_op     = r_bndl.alu_op;
    assign o_is_data    = r_bndl.is_data;
    assign o_data_op    = r_bndl.data_op;
    assign o_rs_addr    = r_bndl.rs_addr;
    assign o_rd_addr    = r_bndl.rd_addr;
    assign o_imm        = r_bndl.imm;
    assign o_reg_we     = r_bndl.reg_we  && r_out_valid;
    assign o_mem_we     = r_bndl.mem_we  && r_out_valid;
    assign o_mem_re     = r_bndl.mem_re  && r_out_valid;
    assign o_flag_we    = r_bndl.flag_we && r_out_valid;
    assign o_issued_cnt = r_issued_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_decode_stage;

    localparam int unsigned LAT = 2;
    localparam int unsigned CW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          iv = 1'b0;
    logic [8:0]    inst = '0;
    logic          in_ready;
    logic          out_rdy = 1'b0;
    logic          out_valid;
    logic [2:0]    alu_op;
    logic          is_data;
    logic [1:0]    data_op;
    logic [2:0]    rs_addr, rd_addr;
    logic [4:0]    imm;
    logic          reg_we, mem_we, mem_re, flag_we;
    logic [CW-1:0] issued_cnt;

    int vectors = 0;
    int miscompares = 0;
    bit started = 1'b0;

    decode_stage #(.LOAD_LAT(LAT), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(iv), .i_inst(inst),
        .o_in_ready(in_ready), .i_out_ready(out_rdy), .o_out_valid(out_valid),
        .o_alu_op(alu_op), .o_is_data(is_data), .o_data_op(data_op),
        .o_rs_addr(rs_addr), .o_rd_addr(rd_addr), .o_imm(imm),
        .o_reg_we(reg_we), .o_mem_we(mem_we), .o_mem_re(mem_re),
        .o_flag_we(flag_we), .o_issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] alu;
        logic       isd;
        logic [1:0] dop;
        logic [2:0] rs;
        logic [2:0] rd;
        logic [4:0] imm;
        logic       rwe, mwe, mre, fwe;
    } ref_t;

    // Reference decode straight from the instruction-format rules.
    function automatic ref_t decode_ref(input logic [8:0] x);
        ref_t r;
        r = '0;
        if (x[8] == 1'b0) begin
            r.alu = x[7:5];
            r.rs  = x[4:2];
            r.imm = x[4:0];
            r.fwe = (x[7:5] == 3'd4);
            r.rwe = !r.fwe;
        end else begin
            r.isd = 1'b1;
            r.dop = x[7:6];
            r.rs  = x[5:3];
            r.rd  = x[2:0];
            r.rwe = (r.dop == 2'd0) || (r.dop == 2'd3);
            r.fwe = (r.dop == 2'd1);
            r.mwe = (r.dop == 2'd2);
            r.mre = (r.dop == 2'd3);
        end
        return r;
    endfunction

    ref_t m_b;
    logic m_ov;
    int   m_stall;
    int   m_cnt;
    logic m_rdy, m_hs, m_acc;

    assign m_rdy = (m_stall == 0) && (!m_ov || out_rdy);
    assign m_hs  = m_ov && out_rdy;
    assign m_acc = iv && m_rdy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_b     <= '0;
            m_ov    <= 1'b0;
            m_stall <= 0;
            m_cnt   <= 0;
        end else begin
            if (m_acc) begin
                m_b  <= decode_ref(inst);
                m_ov <= 1'b1;
            end else if (m_hs) begin
                m_ov <= 1'b0;
            end
            if (m_hs) m_cnt <= (m_cnt + 1) % (1 << CW);
            if (m_hs && m_b.mre) m_stall <= LAT;
            else if (m_stall > 0) m_stall <= m_stall - 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready",   32'(in_ready),   32'(m_rdy));
            chk("out_valid",  32'(out_valid),  32'(m_ov));
            chk("reg_we",     32'(reg_we),     32'(m_ov && m_b.rwe));
            chk("mem_we",     32'(mem_we),     32'(m_ov && m_b.mwe));
            chk("mem_re",     32'(mem_re),     32'(m_ov && m_b.mre));
            chk("flag_we",    32'(flag_we),    32'(m_ov && m_b.fwe));
            chk("issued_cnt", 32'(issued_cnt), 32'(m_cnt));
            if (m_ov || rst) begin
                chk("alu_op",  32'(alu_op),  32'(m_b.alu));
                chk("is_data", 32'(is_data), 32'(m_b.isd));
                chk("data_op", 32'(data_op), 32'(m_b.dop));
                chk("rs_addr", 32'(rs_addr), 32'(m_b.rs));
                chk("rd_addr", 32'(rd_addr), 32'(m_b.rd));
                chk("imm",     32'(imm),     32'(m_b.imm));
            end
        end
    end

    // Handshakes the previous bundle, presents x, and returns at the
    // negedge where x is visible on the outputs.
    task automatic send(input logic [8:0] x);
        @(posedge clk); #1;
        iv = 1'b1; inst = x; out_rdy = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        @(negedge clk); #1;
    endtask

    int bp = 0;

    initial begin
        @(posedge clk);
        started = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("lit_ready_after_reset", 32'(in_ready), 32'd1);

        send(9'b0_000_01101);
        chk("lit_add_valid",  32'(out_valid), 32'd1);
        chk("lit_add_alu",    32'(alu_op),    32'd0);
        chk("lit_add_rs",     32'(rs_addr),   32'd3);
        chk("lit_add_reg_we", 32'(reg_we),    32'd1);

        send(9'b0_100_00100);
        chk("lit_cnt_after_add", 32'(issued_cnt), 32'd1);
        chk("lit_cmp_flag_we",   32'(flag_we),    32'd1);
        chk("lit_cmp_reg_we",    32'(reg_we),     32'd0);

        send(9'b1_01_010_011);
        chk("lit_flag_is_data", 32'(is_data), 32'd1);
        chk("lit_flag_data_op", 32'(data_op), 32'd1);
        chk("lit_flag_flag_we", 32'(flag_we), 32'd1);
        chk("lit_flag_reg_we",  32'(reg_we),  32'd0);

        send(9'b1_11_001_010);
        chk("lit_load_mem_re", 32'(mem_re),  32'd1);
        chk("lit_load_rd",     32'(rd_addr), 32'd2);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("lit_load_stall_ready", 32'(in_ready), (k == 2) ? 32'd1 : 32'd0);
        end

        // backpressure: A held 5 cycles while B waits upstream
        @(posedge clk); #1;
        iv = 1'b1; inst = 9'b0_011_10101; out_rdy = 1'b0;
        @(posedge clk); #1;
        inst = 9'b0_010_01010;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk("lit_bp_valid", 32'(out_valid), 32'd1);
            chk("lit_bp_ready", 32'(in_ready),  32'd0);
            chk("lit_bp_imm",   32'(imm),       32'd21);
        end
        out_rdy = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        @(negedge clk); #1;
        chk("lit_bp_next_imm", 32'(imm),    32'd10);
        chk("lit_bp_next_alu", 32'(alu_op), 32'd2);

        for (int k = 0; k < 9; k++) send({1'b0, 3'($urandom_range(0, 7)), 5'($urandom)});
        @(posedge clk);
        @(negedge clk); #1;
        chk("lit_cnt_max", 32'(issued_cnt), 32'd15);
        send(9'b0_010_00001);
        @(posedge clk);
        @(negedge clk); #1;
        chk("lit_cnt_wrap", 32'(issued_cnt), 32'd0);

        send(9'b1_11_001_010);
        @(posedge clk); #1;
        rst = 1'b1; out_rdy = 1'b0;
        @(negedge clk); #1;
        chk("lit_rst_stall_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("lit_rst_stall_ready", 32'(in_ready),  32'd1);
        chk("lit_rst_stall_valid2", 32'(out_valid), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            iv   = ($urandom_range(0, 9) < 7);
            inst = 9'($urandom);
            if ($urandom_range(0, 3) == 0) inst[8:6] = 3'b111;
            if (bp > 0) begin
                out_rdy = 1'b0;
                bp--;
            end else begin
                out_rdy = ($urandom_range(0, 9) < 6);
                if ($urandom_range(0, 49) == 0) bp = int'($urandom_range(3, 8));
            end
        end
        @(posedge clk); #1;
        iv = 1'b0;
        @(negedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
